// File: rtl/serial_feeder_pkg.sv
// Shared types and defaults for the serial bit feeder.
package serial_feeder_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP_ST} state_e;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_GAP   = 0;
   localparam int DEF_CNT_W = 16;

   // Bits needed to index n positions; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_hold_reg.sv
// One-entry holding buffer in front of the shift register; owns the upstream ready.
module serial_hold_reg
   import serial_feeder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             take_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             ready_o
);

   logic             full_q;
   logic [WIDTH-1:0] data_q;

   // load only arrives while empty and take only while full, so they never collide
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (load_i) begin
         full_q <= 1'b1;
         data_q <= data_i;
      end else if (take_i) begin
         full_q <= 1'b0;
      end
   end

   assign data_o  = data_q;
   assign full_o  = full_q;
   assign ready_o = ~full_q;

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: buffers one word and streams bits MSB first with optional gaps.
module serial_bit_feeder
   import serial_feeder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GAP   = DEF_GAP,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             pause,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             bit_last,
   output logic             busy,
   output logic [CNT_W-1:0] word_count
);

   localparam int IW = idx_w(WIDTH);
   localparam int GW = idx_w(GAP);
   localparam logic [IW-1:0] IDX_MSB   = IW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_END   = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam state_e        AFTER_BIT = (GAP > 0) ? GAP_ST : SHIFT;

   state_e           state_q;
   logic [WIDTH-1:0] shift_q;
   logic [IW-1:0]    idx_q;
   logic [GW-1:0]    gap_q;
   logic [CNT_W-1:0] cnt_q;

   logic             accept, shift_loaded, is_lsb, done;
   logic             hold_full, hold_load, hold_take, direct;
   logic [WIDTH-1:0] hold_data;

   assign accept       = in_valid & in_ready;
   assign shift_loaded = (state_q != IDLE);
   assign is_lsb       = (idx_q == '0);
   assign bit_valid    = (state_q == SHIFT) & ~pause;
   assign done         = bit_valid & is_lsb;

   // A word bypasses the holding register when the shifter is (or is about to be) free.
   assign direct    = accept & ((state_q == IDLE) | (done & ~hold_full));
   assign hold_load = accept & ~direct;
   assign hold_take = done & hold_full;

   serial_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk     (clk),
      .rst     (rst),
      .load_i  (hold_load),
      .take_i  (hold_take),
      .data_i  (in_data),
      .data_o  (hold_data),
      .full_o  (hold_full),
      .ready_o (in_ready)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= IDX_MSB;
         gap_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  shift_q <= in_data;
                  idx_q   <= IDX_MSB;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_valid) begin
                  gap_q <= '0;
                  if (!is_lsb) begin
                     idx_q   <= idx_q - IW'(1);
                     state_q <= AFTER_BIT;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                     // idx stays at the LSB on the way to IDLE so bit_out holds its value
                     if (hold_full || accept) begin
                        shift_q <= hold_full ? hold_data : in_data;
                        idx_q   <= IDX_MSB;
                        state_q <= AFTER_BIT;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
               end
            end
            GAP_ST: begin
               if (gap_q == GAP_END) state_q <= SHIFT;
               else                  gap_q   <= gap_q + GW'(1);
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bit_out    = shift_q[idx_q];
   assign bit_last   = shift_loaded & is_lsb;
   assign busy       = shift_loaded | hold_full;
   assign word_count = cnt_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Scoreboard bench for serial_bit_feeder, run on a no-gap and a gapped configuration.
module tb_serial_bit_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int npass = 0;
   int ntot  = 0;

   task automatic chk(input string nm, input int g, input longint act, input longint exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", g, nm, act, exp, $time);
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int W = (g == 0) ? 4 : 8;
      localparam int G = (g == 0) ? 0 : 2;
      localparam int C = (g == 0) ? 2 : 16;
      localparam logic [W-1:0] P_A = {W/4{4'b1011}};
      localparam logic [W-1:0] P_B = {W/4{4'b0110}};
      localparam logic [W-1:0] P_C = {W/4{4'b1001}};
      localparam logic [W-1:0] P_R = (W == 8) ? W'(8'hA5) : W'(4'hA);
      localparam logic [W-1:0] P_F = W'(8'h0F);

      logic         rst = 1'b1;
      logic [W-1:0] in_data = '0;
      logic         in_valid = 1'b0;
      logic         pause = 1'b0;
      logic         in_ready, bit_out, bit_valid, bit_last, busy;
      logic [C-1:0] word_count;
      bit           fin = 1'b0;
      bit           fin_seen = 1'b0;
      bit           rflag = 1'b0;
      int           to_cnt = 0;

      serial_bit_feeder #(.WIDTH(W), .GAP(G), .CNT_W(C)) dut (
         .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
         .pause(pause), .bit_out(bit_out), .bit_valid(bit_valid), .bit_last(bit_last),
         .busy(busy), .word_count(word_count)
      );

      // Reference model: expected bit stream, words in flight, next cycle a bit may appear.
      bit q_b[$];
      bit q_l[$];
      int inflight = 0, wc_exp = 0, nrdy = 0, cyc = 0;

      initial forever begin
         bit exp_v, done;
         @(negedge clk);
         if (rst) begin
            chk("rst_bit_valid", g, bit_valid, 0);
            chk("rst_bit_last", g, bit_last, 0);
            chk("rst_bit_out", g, bit_out, 0);
            chk("rst_in_ready", g, in_ready, 1);
            chk("rst_busy", g, busy, 0);
            chk("rst_word_count", g, word_count, 0);
            q_b.delete(); q_l.delete();
            inflight = 0; wc_exp = 0; nrdy = 0;
         end else begin
            exp_v = (q_b.size() > 0) && (cyc >= nrdy) && !pause;
            chk("word_count", g, word_count, wc_exp);
            chk("in_ready", g, in_ready, inflight < 2);
            chk("busy", g, busy, inflight > 0);
            chk("bit_valid", g, bit_valid, exp_v);
            done = 1'b0;
            if (bit_valid) begin
               if (q_b.size() == 0) chk("spurious_bit", g, bit_valid, 0);
               else begin
                  chk("bit_out", g, bit_out, q_b[0]);
                  chk("bit_last", g, bit_last, q_l[0]);
                  nrdy = cyc + 1 + G;
                  if (q_l[0]) begin
                     inflight--;
                     wc_exp = (wc_exp + 1) % (1 << C);
                     done = 1'b1;
                  end
                  void'(q_b.pop_front());
                  void'(q_l.pop_front());
               end
            end
            if (in_valid && in_ready) begin
               if (inflight == 0 && !done) nrdy = cyc + 1;
               for (int i = W - 1; i >= 0; i--) begin
                  q_b.push_back(in_data[i]);
                  q_l.push_back(i == 0);
               end
               inflight++;
            end
         end
         if (fin && !fin_seen) begin
            chk("drv_timeouts", g, to_cnt, 0);
            fin_seen = 1'b1;
         end
         cyc++;
      end

      task automatic tick(input int n);
         repeat (n) @(posedge clk);
         #1;
      endtask

      task automatic send(input logic [W-1:0] w);
         int n;
         in_data  = w;
         in_valid = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!in_ready && n < 300);
         if (!in_ready) to_cnt++;
         tick(1);
         in_valid = 1'b0;
      endtask

      task automatic wait_idle();
         int n = 0;
         while (busy && n < 500) begin tick(1); n++; end
         if (busy) to_cnt++;
         tick(1);
      endtask

      task automatic wait_last();
         int n = 0;
         while (!(bit_valid && bit_last) && n < 200) begin tick(1); n++; end
         if (!(bit_valid && bit_last)) to_cnt++;
      endtask

      initial begin
         int n;
         tick(3);
         rst = 1'b0;
         tick(1);
         send(P_A);                       // single word
         wait_idle();
         send(P_A); send(P_B); send(P_C); // back-to-back through hold
         wait_idle();
         send(P_C);                       // pause across the second bit slot
         tick(1 + G);
         pause = 1'b1;
         tick(3);
         pause = 1'b0;
         wait_idle();
         send(W'($urandom));              // same-edge accepts, counter wrap
         for (int k = 0; k < 5; k++) begin
            wait_last();
            in_data  = W'($urandom);
            in_valid = 1'b1;
            tick(1);
            in_valid = 1'b0;
         end
         wait_idle();
         send(P_R); send(P_B);            // async reset mid-word with hold occupied
         n = 0;
         while (n < 2) begin
            @(negedge clk);
            if (bit_valid) n++;
         end
         @(posedge clk); #3;
         rst = 1'b1;
         @(posedge clk); @(posedge clk); #3;
         rst = 1'b0;
         tick(1);
         send(P_F);
         wait_idle();
         fork
            begin
               repeat (40) begin
                  tick($urandom_range(0, 3));
                  send(W'($urandom));
               end
               rflag = 1'b1;
            end
            begin
               while (!rflag) begin
                  pause = ($urandom_range(0, 3) == 0);
                  tick(1);
               end
               pause = 1'b0;
            end
         join
         wait_idle();
         fin = 1'b1;
      end
   end

   initial begin
      fork
         wait (cfg[0].fin_seen && cfg[1].fin_seen);
         begin
            #800000;
            $display("FAIL global_timeout: bench did not complete, got timeout expected completion");
            $fatal(1, "bench timeout");
         end
      join_any
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/serial_bit_feeder.md
Name: serial_bit_feeder

Overview:
Upstream stage of the serial "1011" sequence detector. Accepts parallel words over a valid/ready handshake, buffers one word, and shifts each word out one bit per transfer, MSB first, with a bit strobe. An optional inter-bit gap lets the detector see each bit as a distinct input event. A downstream pause input can stall it.

Parameters:
WIDTH, 8, word width in bits (>=2)
GAP, 0, idle cycles inserted after each transferred bit (0 = back-to-back bits)
CNT_W, 16, width of the completed-word counter

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  parallel word, MSB shifted first
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
pause  input  1  downstream stall; freezes bit stream
bit_out  output  1  current serial bit
bit_valid  output  1  bit_out is presented; a transfer occurs on each rising edge with bit_valid=1
bit_last  output  1  bit_out is the LSB (final bit) of the current word
busy  output  1  shift register or holding register occupied
word_count  output  CNT_W  number of words fully shifted out, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any time, including mid-word): bit_out=0, bit_valid=0, bit_last=0, in_ready=1, busy=0, word_count=0, FSM=IDLE. Shift and holding contents are discarded; a partial word is not counted.
- Accept: a word is taken on a rising edge with in_valid=1 and in_ready=1. Upstream holds in_data stable while in_valid=1 and in_ready=0.
- in_ready = NOT hold_full (combinational from a register). It may be high while shifting.
- FSM states:
  - IDLE: no word loaded. On accept, load the word into the shift register (hold stays empty) and go to SHIFT.
  - SHIFT: present the current bit. bit_valid = shift_loaded AND NOT pause. When a bit transfers: if it was the last bit, the word is done; otherwise advance the bit index and go to GAP (GAP>0) or stay in SHIFT (GAP=0).
  - GAP: bit_valid=0, gap counter counts GAP cycles, then return to SHIFT. The counter counts regardless of pause.
- Latency: the first bit appears with bit_valid=1 in the cycle after the accepting edge, provided pause=0.
- pause=1: bit_valid=0 combinationally. Bit index, bit_out and bit_last hold their values. Acceptance into the holding register is unaffected.
- Word done, on the edge where the last bit transfers:
  - word_count increments.
  - If hold is full: move hold to shift, clear hold, and continue via GAP or SHIFT as for a normal bit. There is no extra bubble.
  - Else if an accept occurs on the same edge: the new word goes directly into the shift register.
  - Else: go to IDLE.
- Simultaneous accept while shifting with hold empty: the word goes into hold, and in_ready drops on the next cycle.
- bit_last=1 exactly when the bit index is the LSB position.
- busy = shift_loaded OR hold_full.
- word_count wraps from 2^CNT_W-1 to 0 with no flag.
- bit_out holds its last value when idle. It is don't-care whenever bit_valid=0 for checking purposes, but must not glitch from X after reset.

Decomposition:
- Package serial_feeder_pkg holds:
  - state enum {IDLE, SHIFT, GAP}
  - default WIDTH/GAP/CNT_W constants
  - a function giving the bit-index width, clog2(WIDTH)
- One sub-module, serial_hold_reg: a one-entry WIDTH-bit holding buffer with load/take/full. It also owns in_ready.
- The FSM, shift register, gap counter and word counter stay in the top module.

Test Plan:
- Basic word: WIDTH=4, GAP=0, pause=0. Accept 4'b1011 at edge 0 -> bit_valid high for cycles 1-4 with bits 1,0,1,1; bit_last=1 only in cycle 4; word_count=1 after cycle 4; FSM returns to IDLE; busy=0.
- Back-to-back buffering: WIDTH=4. Present 4'b1011 then 4'b0110 continuously -> second word held while in_ready=0; bit stream 1,0,1,1,0,1,1,0 with no gap cycle; word_count=2.
- Gap and pause: GAP=2. Send 4'b1001 with pause=1 during the 2nd bit slot for 3 cycles -> each bit followed by exactly 2 bit_valid=0 cycles; 2nd bit (0) is held and delivered once after pause drops; no bit is lost or duplicated.
- Reset mid-word: WIDTH=8. Assert rst asynchronously (off-edge) after 3 bits of 8'hA5, with a word also in hold -> all outputs return to reset values immediately, word_count stays 0, in_ready=1. The next word 8'h0F then shifts cleanly.
- Counter wrap and same-edge accept: CNT_W=2, hold empty. Send 5 words with in_valid asserted on each last-bit edge -> each new word enters shift directly with no IDLE cycle; word_count sequence 1,2,3,0,1.
